// File: rtl/alu_pkg.sv
// Shared definitions for the ALU requester: opcodes, error data, FSM states and the command record.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  localparam logic [15:0] ERR_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ISSUE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  sel;
  } cmd_t;

  function automatic logic is_div_zero(input cmd_t c);
    return (c.sel == OP_DIV) && (c.b == 16'd0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: RAM-style storage with registered read; pop only loads rd_data, it never bypasses.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + 1'b1;
    else if (!do_push && do_pop)
      count_next = count - 1'b1;
  end

  // full is held high through reset so the upstream sees no ready until the first clock after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
    if (do_pop)  rd_data     <= mem[rd_ptr];
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Requester front end: buffers commands, screens divide-by-zero, drives the ALU and returns tagged responses.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  input  logic [2:0]       cmd_sel,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [2:0]       alu_sel,
  input  logic [15:0]      alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag
);

  state_t           state;
  cmd_t             cmd_in;
  cmd_t             head;
  cmd_t             op;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             fetch;
  logic [2:0]       wait_cnt;
  logic [TAG_W-1:0] tag_cnt;

  assign cmd_in    = {cmd_a, cmd_b, cmd_sel};
  assign cmd_ready = !fifo_full;

  // Popping on the response handshake overlaps the FIFO read with leaving RESP
  assign fifo_pop = !fifo_empty &&
                    (((state == ST_IDLE) && !fetch) || ((state == ST_RESP) && rsp_ready));

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push    (cmd_valid),
    .wr_data (cmd_in),
    .pop     (fifo_pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      fetch     <= 1'b0;
      op        <= '0;
      wait_cnt  <= '0;
      tag_cnt   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rsp_tag   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fetch) begin
            op    <= head;
            fetch <= 1'b0;
            state <= ST_CHECK;
          end else if (fifo_pop) begin
            fetch <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (is_div_zero(op)) begin
            rsp_data  <= ERR_DATA;
            rsp_err   <= 1'b1;
            rsp_tag   <= tag_cnt;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            alu_a    <= op.a;
            alu_b    <= op.b;
            alu_sel  <= op.sel;
            wait_cnt <= 3'(ALU_LAT - 1);
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (wait_cnt == 3'd0) begin
            rsp_data  <= alu_out;
            rsp_err   <= 1'b0;
            rsp_tag   <= tag_cnt;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            tag_cnt   <= tag_cnt + 1'b1;
            fetch     <= fifo_pop;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench: two sequencer instances (ALU latency 1 and 3) against a queue-based response model.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int lanes_done = 0;

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] s);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return p[15:0];
      3'd3:    return (b == 16'd0) ? 16'hDEAD : a / b;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic chk(input int lane, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL lane%0d %s: got %0h expected %0h at %0t", lane, name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : lane
    localparam int LAT = (gi == 0) ? 1 : 3;
    localparam int PI  = (LAT > 1) ? LAT - 2 : 0;

    logic        rst = 1'b0;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [15:0] cmd_a, cmd_b, alu_a, alu_b, alu_out, rsp_data;
    logic [2:0]  cmd_sel, alu_sel;
    logic [3:0]  rsp_tag;
    logic [34:0] pipe [0:5];
    exp_t        q[$];
    int          acc = 0;
    int          rsp_seen = 0;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(LAT), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
    );

    // ALU model: result valid LAT cycles after the operands are driven
    always @(posedge clk) begin
      pipe[0] <= {alu_a, alu_b, alu_sel};
      for (int i = 1; i < 6; i++) pipe[i] <= pipe[i-1];
    end
    always_comb begin
      if (LAT == 1) alu_out = alu_f(alu_a, alu_b, alu_sel);
      else          alu_out = alu_f(pipe[PI][34:19], pipe[PI][18:3], pipe[PI][2:0]);
    end

    // Reference: every accepted command owes one response, in order, tagged by acceptance count
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        acc <= 0;
      end else begin
        chk(gi, "div0_screen", 32'((alu_sel == 3'd3) && (alu_b == 16'd0)), 32'd0);
        if (q.size() < DEPTH) chk(gi, "cmd_ready_room", 32'(cmd_ready), 32'd1);
        if (q.size() > DEPTH) chk(gi, "cmd_ready_full", 32'(cmd_ready), 32'd0);
        if (rsp_valid) begin
          chk(gi, "rsp_owner", 32'(rsp_valid), 32'(q.size() != 0));
          if (q.size() != 0) chk(gi, "rsp", 32'({rsp_data, rsp_err, rsp_tag}), 32'(q[0]));
          if (rsp_ready) begin
            if (q.size() != 0) void'(q.pop_front());
            rsp_seen <= rsp_seen + 1;
          end
        end
        if (cmd_valid && cmd_ready) begin
          exp_t e;
          e.err  = (cmd_sel == 3'd3) && (cmd_b == 16'd0);
          e.data = e.err ? 16'hFFFF : alu_f(cmd_a, cmd_b, cmd_sel);
          e.tag  = 4'(acc);
          q.push_back(e);
          acc <= acc + 1;
        end
      end
    end

    task automatic out_zero(input string name);
      chk(gi, {name, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
      chk(gi, {name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk(gi, {name, "_rsp_data"},  32'(rsp_data),  32'd0);
      chk(gi, {name, "_rsp_err"},   32'(rsp_err),   32'd0);
      chk(gi, {name, "_rsp_tag"},   32'(rsp_tag),   32'd0);
      chk(gi, {name, "_alu_a"},     32'(alu_a),     32'd0);
      chk(gi, {name, "_alu_b"},     32'(alu_b),     32'd0);
      chk(gi, {name, "_alu_sel"},   32'(alu_sel),   32'd0);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
      int w = 0;
      cmd_a = a; cmd_b = b; cmd_sel = s; cmd_valid = 1'b1;
      @(negedge clk);
      while (!cmd_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      chk(gi, "send_bound", 32'(w < 50), 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
      int w = 0;
      while ((q.size() != 0 || rsp_valid) && w < 300) begin
        @(posedge clk);
        #1 w++;
      end
      chk(gi, "drain_bound", 32'(w < 300), 32'd1);
    endtask

    task automatic latency_run(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s,
                               input logic [15:0] exp_data, input logic exp_err,
                               input logic [3:0] exp_tag, input int exp_lat, input bit chk_alu);
      int k = 0;
      rsp_ready = 1'b1;
      wait_idle();
      cmd_a = a; cmd_b = b; cmd_sel = s; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      while (k < 40) begin
        @(posedge clk);
        #1 k++;
        if (chk_alu && k >= 3 && k < 3 + LAT) begin
          chk(gi, "issue_alu_a",   32'(alu_a),   32'(a));
          chk(gi, "issue_alu_b",   32'(alu_b),   32'(b));
          chk(gi, "issue_alu_sel", 32'(alu_sel), 32'(s));
        end
        if (rsp_valid) break;
      end
      $display("lane%0d op=%0d a=%h b=%h -> data=%h err=%0d tag=%0d after %0d cycles",
               gi, s, a, b, rsp_data, rsp_err, rsp_tag, k);
      chk(gi, "latency",  32'(k),        32'(exp_lat));
      chk(gi, "lit_data", 32'(rsp_data), 32'(exp_data));
      chk(gi, "lit_err",  32'(rsp_err),  32'(exp_err));
      chk(gi, "lit_tag",  32'(rsp_tag),  32'(exp_tag));
    endtask

    initial begin
      int base;
      cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; rsp_ready = 1'b0;
      #2 rst = 1'b1;
      #1 out_zero("reset");
      repeat (3) @(posedge clk);
      #7 rst = 1'b0;
      @(posedge clk);
      #1 chk(gi, "ready_after_reset", 32'(cmd_ready), 32'd1);

      // Backpressure: one command parked in RESP, four in the FIFO, sixth refused
      rsp_ready = 1'b0;
      base = rsp_seen;
      for (int i = 0; i < 5; i++)
        send(16'($urandom), 16'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      cmd_valid = 1'b1;
      @(negedge clk);
      chk(gi, "sixth_refused", 32'(cmd_ready), 32'd0);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_idle();
      chk(gi, "bp_responses", 32'(rsp_seen - base), 32'd5);

      latency_run(16'd3080, 16'd756, 3'd0, 16'd3836, 1'b0, 4'd5, 3 + LAT, 1'b1);
      latency_run(16'd100, 16'd0, 3'd3, 16'hFFFF, 1'b1, 4'd6, 3, 1'b0);
      latency_run(16'h2560, 16'h72E0, 3'd6, 16'h5780, 1'b0, 4'd7, 3 + LAT, 1'b1);

      for (int c = 0; c < 1500; c++) begin
        cmd_valid = ($urandom_range(0, 9) < 6);
        cmd_a     = 16'($urandom);
        cmd_b     = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
        cmd_sel   = ($urandom_range(0, 3) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
        rsp_ready = ($urandom_range(0, 9) < 7);
        @(posedge clk);
        #1;
      end

      // Reset with traffic in flight: outputs clear at once, numbering restarts at 0
      #2 rst = 1'b1;
      cmd_valid = 1'b0;
      #1 out_zero("midreset");
      repeat (2) @(posedge clk);
      #7 rst = 1'b0;
      @(posedge clk);
      #1 chk(gi, "ready_after_midreset", 32'(cmd_ready), 32'd1);
      latency_run(16'd3080, 16'd756, 3'd0, 16'd3836, 1'b0, 4'd0, 3 + LAT, 1'b1);

      lanes_done++;
    end
  end

  initial begin
    wait (lanes_done == 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, lanes_done=%0d", lanes_done);
    $fatal(1, "watchdog expired");
  end

endmodule
